time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl_pkg.sv | 38 +++
 rtl/time_set_ctrl_if.sv | 33 +++
 rtl/btn_debounce.sv | 60 ++++++
 rtl/time_set_ctrl.sv | 158 +++++++++++++++
 tb/tb_time_set_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/time_set_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// time_set_ctrl_pkg
// Shared definitions for the clock time-setting controller:
//   - FSM state encoding (legacy-compatible 3-bit constants)
//   - BCD digit wrap limits (tens digits wrap at 5, units digits at 9)
//   - default parameter values
//   - small BCD helper functions
// ----------------------------------------------------------------------------
package time_set_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_RUN    = 3'd0;
    localparam state_t ST_SET3   = 3'd1;
    localparam state_t ST_SET2   = 3'd2;
    localparam state_t ST_SET1   = 3'd3;
    localparam state_t ST_SET0   = 3'd4;
    localparam state_t ST_COMMIT = 3'd5;

    localparam logic [3:0] LIM_TENS  = 4'd5;
    localparam logic [3:0] LIM_UNITS = 4'd9;

    localparam int DEF_DEB_SAMPLES = 10;
    localparam int DEF_TIMEOUT_S   = 10;
    localparam int DEF_BLINK_TICKS = 125;

    // Odd digit positions (minutes tens, seconds tens) are tens digits.
    function automatic logic [3:0] digit_limit(input logic [1:0] idx);
        return idx[0] ? LIM_TENS : LIM_UNITS;
    endfunction

    // Values at or above the limit wrap to 0, so an out-of-range digit
    // copied from the counter is pulled back into range on the first press.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d, input logic [3:0] lim);
        return (d >= lim) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// ----------------------------------------------------------------------------
// time_set_ctrl_if
// Controller <-> time counter bundle.
//   cur0..cur3   : live counter digits (BCD, cur0 = seconds units)
//   run_en       : counter count-enable
//   load         : single-cycle load strobe
//   load0..load3 : digit values to load, valid while load = 1
// master = controller side, slave = counter side.
// ----------------------------------------------------------------------------
interface time_set_ctrl_if;

    logic [3:0] cur0;
    logic [3:0] cur1;
    logic [3:0] cur2;
    logic [3:0] cur3;
    logic       run_en;
    logic       load;
    logic [3:0] load0;
    logic [3:0] load1;
    logic [3:0] load2;
    logic [3:0] load3;

    modport master (
        input  cur0, cur1, cur2, cur3,
        output run_en, load, load0, load1, load2, load3
    );

    modport slave (
        output cur0, cur1, cur2, cur3,
        input  run_en, load, load0, load1, load2, load3
    );

endinterface

// File: rtl/btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// Synchronises a raw asynchronous push-button, debounces it on the sample
// tick and emits a one-clock pulse on each accepted 0->1 transition.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   tick       : sample strobe (500 Hz, one clk wide)
//   btn_raw    : raw button, active-high, asynchronous
//   press      : one-clk pulse when the debounced level rises
// ----------------------------------------------------------------------------
module btn_debounce
    import time_set_ctrl_pkg::*;
#(
    parameter int DEB_SAMPLES = DEF_DEB_SAMPLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = $clog2(DEB_SAMPLES + 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;
    logic          accept;

    // cnt counts consecutive samples that disagree with the accepted level;
    // the DEB_SAMPLES-th such sample flips the level.
    assign accept = tick && (sync[1] != level) && (cnt == CW'(DEB_SAMPLES - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            // NOTE: two flops before any logic looks at the button, so a
            // metastable first stage never reaches the debounce counter.
            sync  <= {sync[0], btn_raw};
            press <= accept && sync[1];
            if (tick) begin
                if (sync[1] == level) begin
                    cnt <= '0;
                end else if (accept) begin
                    level <= sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// ----------------------------------------------------------------------------
// time_set_ctrl
// Two-button time-setting controller for an MM:SS counter.
//   mode button : enter set mode, step SET3 -> SET2 -> SET1 -> SET0 -> commit
//   inc button  : increment the digit being edited (BCD wrap 5 or 9)
// Idle in set mode for TIMEOUT_S seconds aborts without loading.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   tick_1hz, tick_500hz : single-cycle timebase pulses
//   btn_mode, btn_inc    : raw push-buttons, active-high
//   blink_mask           : bit n = 1 blanks display digit n
//   bus (master)         : cur0..3 in; run_en, load, load0..3 out
// ----------------------------------------------------------------------------
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int DEB_SAMPLES = DEF_DEB_SAMPLES,
    parameter int TIMEOUT_S   = DEF_TIMEOUT_S,
    parameter int BLINK_TICKS = DEF_BLINK_TICKS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_500hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] blink_mask,
    time_set_ctrl_if.master bus
);

    localparam int IW = $clog2(TIMEOUT_S + 1);
    localparam int BW = $clog2(BLINK_TICKS + 1);

    logic          mode_ev;
    logic          inc_ev;
    state_t        state;
    state_t        state_nxt;
    logic [3:0]    edit [4];
    logic [1:0]    sel;
    logic          in_set;
    logic          entering;
    logic          timeout;
    logic [IW-1:0] idle_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_on;

    btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_mode (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick_500hz),
        .btn_raw (btn_mode),
        .press   (mode_ev)
    );

    btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_inc (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick_500hz),
        .btn_raw (btn_inc),
        .press   (inc_ev)
    );

    assign in_set = (state == ST_SET3) || (state == ST_SET2) ||
                    (state == ST_SET1) || (state == ST_SET0);

    // Any press restarts the idle window, so it also blocks a timeout
    // landing on the same cycle.
    assign timeout = in_set && tick_1hz && !(mode_ev || inc_ev) &&
                     (idle_cnt == IW'(TIMEOUT_S - 1));

    assign entering = (state_nxt != state) &&
                      ((state_nxt == ST_SET3) || (state_nxt == ST_SET2) ||
                       (state_nxt == ST_SET1) || (state_nxt == ST_SET0));

    // NOTE: every combinational output gets a default before the case so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel = 2'd0;
        case (state)
            ST_SET3: sel = 2'd3;
            ST_SET2: sel = 2'd2;
            ST_SET1: sel = 2'd1;
            default: sel = 2'd0;
        endcase
    end

    // Mode always wins over inc; a mode press leaves the current digit
    // untouched.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (mode_ev) state_nxt = ST_SET3;
            ST_SET3:   if (mode_ev) state_nxt = ST_SET2;  else if (timeout) state_nxt = ST_RUN;
            ST_SET2:   if (mode_ev) state_nxt = ST_SET1;  else if (timeout) state_nxt = ST_RUN;
            ST_SET1:   if (mode_ev) state_nxt = ST_SET0;  else if (timeout) state_nxt = ST_RUN;
            ST_SET0:   if (mode_ev) state_nxt = ST_COMMIT; else if (timeout) state_nxt = ST_RUN;
            ST_COMMIT: state_nxt = ST_RUN;
            default:   state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            idle_cnt  <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b0;
            // NOTE: the edit registers are four flops each, not a RAM, so
            // resetting them is cheap and makes load0..3 read 0 out of reset.
            for (int i = 0; i < 4; i++) edit[i] <= 4'd0;
        end else begin
            state <= state_nxt;

            if (state == ST_RUN && mode_ev) begin
                edit[0] <= bus.cur0;
                edit[1] <= bus.cur1;
                edit[2] <= bus.cur2;
                edit[3] <= bus.cur3;
            end else if (in_set && inc_ev && !mode_ev) begin
                edit[sel] <= bcd_inc(edit[sel], digit_limit(sel));
            end

            if (!in_set || mode_ev || inc_ev) begin
                idle_cnt <= '0;
            end else if (tick_1hz) begin
                idle_cnt <= timeout ? '0 : idle_cnt + 1'b1;
            end

            // Each SETn starts with its digit visible.
            if (entering || !in_set) begin
                blink_cnt <= '0;
                blink_on  <= 1'b0;
            end else if (tick_500hz) begin
                if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                    blink_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        blink_mask = 4'b0000;
        if (in_set && blink_on) blink_mask[sel] = 1'b1;
    end

    // Outputs decode straight from reset flops, so they take their reset
    // values as soon as rst_n falls.
    assign bus.run_en = (state == ST_RUN);
    assign bus.load   = (state == ST_COMMIT);
    assign bus.load0  = edit[0];
    assign bus.load1  = edit[1];
    assign bus.load2  = edit[2];
    assign bus.load3  = edit[3];

endmodule

// File: tb/tb_time_set_ctrl.sv
// ----------------------------------------------------------------------------
// tb_time_set_ctrl
// Directed self-checking bench for time_set_ctrl. tick_500hz is a free
// running pulse every 4 clocks; tick_1hz is pulsed by hand. A monitor
// records every cycle with load high and the load digits seen there.
// ----------------------------------------------------------------------------
module tb_time_set_ctrl;

    localparam int DEB   = 10;
    localparam int TOUT  = 10;
    localparam int BLINK = 8;
    localparam int HOLD  = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       tick_500hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] blink_mask;

    int         n_checks = 0;
    int         n_fails = 0;
    int         load_cycles = 0;
    logic [15:0] last_load = '0;
    int         tcnt = 0;

    time_set_ctrl_if ifc ();

    time_set_ctrl #(
        .DEB_SAMPLES (DEB),
        .TIMEOUT_S   (TOUT),
        .BLINK_TICKS (BLINK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1hz   (tick_1hz),
        .tick_500hz (tick_500hz),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .blink_mask (blink_mask),
        .bus        (ifc)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        tcnt = tcnt + 1;
        tick_500hz = (tcnt % 4 == 0);
    end

    always @(negedge clk) begin
        if (ifc.load === 1'b1) begin
            load_cycles = load_cycles + 1;
            last_load = {ifc.load3, ifc.load2, ifc.load1, ifc.load0};
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic m, input logic i);
        @(negedge clk);
        btn_mode = m;
        btn_inc  = i;
        repeat (HOLD) @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic wait_run_en(input string tag, input logic want, input int budget);
        int n = 0;
        while (ifc.run_en !== want && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {15'd0, ifc.run_en}, {15'd0, want});
    endtask

    task automatic pulse_1hz();
        @(negedge clk);
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic set_cur(input logic [3:0] d3, input logic [3:0] d2,
                           input logic [3:0] d1, input logic [3:0] d0);
        ifc.cur3 = d3;
        ifc.cur2 = d2;
        ifc.cur1 = d1;
        ifc.cur0 = d0;
    endtask

    initial begin
        int n;
        set_cur(4'd0, 4'd0, 4'd0, 4'd0);

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_run_en", {15'd0, ifc.run_en}, 16'd1);
        check("rst_load", {15'd0, ifc.load}, 16'd0);
        check("rst_loadval", {ifc.load3, ifc.load2, ifc.load1, ifc.load0}, 16'h0000);
        check("rst_blink", {12'd0, blink_mask}, 16'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Bounce: ~4 samples high must be ignored
        set_cur(4'd5, 4'd9, 4'd5, 4'd9);
        btn_mode = 1'b1;
        repeat (16) @(negedge clk);
        btn_mode = 1'b0;
        repeat (HOLD) @(negedge clk);
        check("bounce_ignored", {15'd0, ifc.run_en}, 16'd1);

        // Stable press enters SET3; blink starts visible, toggles after BLINK ticks
        btn_mode = 1'b1;
        wait_run_en("set3_entry", 1'b0, 80);
        check("blink_entry", {12'd0, blink_mask}, 16'd0);
        n = 0;
        while (n < BLINK - 1) begin
            @(posedge clk);
            if (tick_500hz) n++;
        end
        #1 check("blink_before", {12'd0, blink_mask}, 16'd0);
        while (n < BLINK) begin
            @(posedge clk);
            if (tick_500hz) n++;
        end
        #1 check("blink_on_d3", {12'd0, blink_mask}, 16'h0008);
        @(negedge clk);
        check("set3_no_load", {15'd0, ifc.load}, 16'd0);
        repeat (20) @(negedge clk);
        btn_mode = 1'b0;
        repeat (HOLD) @(negedge clk);
        check("held_one_event", {15'd0, ifc.run_en}, 16'd0);

        // 59:59, one inc per digit -> all wrap to 0, commit
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        check("wrap_load_cycles", load_cycles[15:0], 16'd1);
        check("wrap_load_val", last_load, 16'h0000);
        check("wrap_run_en", {15'd0, ifc.run_en}, 16'd1);

        // SET2: 3 + 12 incs wraps via 9->0 to 5
        set_cur(4'd2, 4'd3, 4'd4, 4'd7);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("inc12_load_cycles", load_cycles[15:0], 16'd2);
        check("inc12_load_val", last_load, 16'h2547);

        // Idle timeout: 9 seconds stays, 10th aborts with no load
        set_cur(4'd1, 4'd1, 4'd1, 4'd1);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        for (int i = 0; i < TOUT - 1; i++) pulse_1hz();
        check("idle_9s_set", {15'd0, ifc.run_en}, 16'd0);
        pulse_1hz();
        check("idle_timeout_run", {15'd0, ifc.run_en}, 16'd1);
        check("idle_no_load", load_cycles[15:0], 16'd2);

        // Mode + inc together in SET1: mode wins, digit 1 unchanged
        set_cur(4'd1, 4'd2, 4'd3, 4'd4);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        check("simul_load_cycles", load_cycles[15:0], 16'd3);
        check("simul_load_val", last_load, 16'h1235);

        // Reset in SET0: outputs return asynchronously, no load afterwards
        set_cur(4'd3, 4'd3, 4'd3, 4'd3);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check("set0_run_en", {15'd0, ifc.run_en}, 16'd0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_run_en", {15'd0, ifc.run_en}, 16'd1);
        check("arst_load", {15'd0, ifc.load}, 16'd0);
        check("arst_loadval", {ifc.load3, ifc.load2, ifc.load1, ifc.load0}, 16'h0000);
        check("arst_blink", {12'd0, blink_mask}, 16'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("post_rst_no_load", load_cycles[15:0], 16'd3);
        check("post_rst_run_en", {15'd0, ifc.run_en}, 16'd1);

        // First press after reset needs the full debounce window
        btn_mode = 1'b1;
        repeat (30) @(negedge clk);
        check("early_press_ignored", {15'd0, ifc.run_en}, 16'd1);
        wait_run_en("post_rst_press", 1'b0, 60);
        btn_mode = 1'b0;
        repeat (HOLD) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
